// File: rtl/oq_rr_port_arbiter_pkg.sv
// Shared state encoding and sizing helper for the output-queue round-robin arbiter.
package oq_rr_port_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_XFER = 1'b1
  } arb_state_e;

  // Ceiling log2, never below 1 so a single-queue build still gets a legal index width.
  function automatic int log2(input int value);
    int result;
    result = 1;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fall-through FIFO: the head word is visible on dout whenever empty is low.
module fallthrough_small_fifo #(
  parameter int WIDTH          = 72,
  parameter int MAX_DEPTH_BITS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             nearly_full,
  output logic             empty
);

  localparam int DEPTH = 1 << MAX_DEPTH_BITS;
  localparam logic [MAX_DEPTH_BITS:0] FULL_CNT = (MAX_DEPTH_BITS+1)'(DEPTH);
  localparam logic [MAX_DEPTH_BITS:0] NF_CNT   = (MAX_DEPTH_BITS+1)'(DEPTH - 1);

  logic [WIDTH-1:0]          mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr;
  logic [MAX_DEPTH_BITS:0]   count;
  logic                      do_wr;
  logic                      do_rd;

  // Writes into a full FIFO are dropped; the sender was told to stop one word earlier.
  assign do_wr       = wr_en && (count != FULL_CNT);
  assign do_rd       = rd_en && !empty;
  assign empty       = (count == '0);
  assign nearly_full = (count >= NF_CNT);
  assign dout        = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/oq_rr_port_arbiter.sv
// Packet-granular round-robin merge of NUM_QUEUES NetFPGA streams onto one downstream port.
//   state    | meaning
//   ARB_IDLE | pick next eligible input at/after rr_ptr; no pop this cycle
//   ARB_XFER | forward words of granted input until its end-of-packet word
module oq_rr_port_arbiter
  import oq_rr_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH         = 64,
  parameter int CTRL_WIDTH         = DATA_WIDTH / 8,
  parameter int NUM_QUEUES         = 8,
  parameter int NUM_QUEUES_WIDTH   = log2(NUM_QUEUES),
  parameter int IN_FIFO_DEPTH_BITS = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_QUEUES*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_QUEUES*CTRL_WIDTH-1:0] in_ctrl,
  input  logic [NUM_QUEUES-1:0]            in_wr,
  output logic [NUM_QUEUES-1:0]            in_rdy,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [CTRL_WIDTH-1:0]            out_ctrl,
  output logic                             out_wr,
  input  logic                             out_rdy,
  input  logic [NUM_QUEUES-1:0]            disable_mask,
  output logic                             grant_valid,
  output logic [NUM_QUEUES_WIDTH-1:0]      grant_id,
  output logic [NUM_QUEUES-1:0]            pkt_done
);

  arb_state_e                       state;
  arb_state_e                       state_nxt;
  logic [NUM_QUEUES_WIDTH-1:0]      grant_nxt;
  logic [NUM_QUEUES_WIDTH-1:0]      rr_ptr;
  logic [NUM_QUEUES_WIDTH-1:0]      rr_ptr_nxt;
  logic [NUM_QUEUES_WIDTH-1:0]      rr_pick;
  logic                             prev_ctrl;
  logic                             prev_ctrl_nxt;
  logic [NUM_QUEUES-1:0]            eligible;
  logic [NUM_QUEUES-1:0]            fifo_empty;
  logic [NUM_QUEUES-1:0]            fifo_nearly_full;
  logic [NUM_QUEUES-1:0]            fifo_rd;
  logic [NUM_QUEUES-1:0]            pkt_done_nxt;
  logic [DATA_WIDTH+CTRL_WIDTH-1:0] fifo_dout [NUM_QUEUES];
  logic [DATA_WIDTH-1:0]            head_data;
  logic [CTRL_WIDTH-1:0]            head_ctrl;
  logic                             pop;
  logic                             eop;

  for (genvar i = 0; i < NUM_QUEUES; i++) begin : g_in_fifo
    fallthrough_small_fifo #(
      .WIDTH          (DATA_WIDTH + CTRL_WIDTH),
      .MAX_DEPTH_BITS (IN_FIFO_DEPTH_BITS)
    ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .din         ({in_ctrl[i*CTRL_WIDTH +: CTRL_WIDTH], in_data[i*DATA_WIDTH +: DATA_WIDTH]}),
      .wr_en       (in_wr[i]),
      .rd_en       (fifo_rd[i]),
      .dout        (fifo_dout[i]),
      .nearly_full (fifo_nearly_full[i]),
      .empty       (fifo_empty[i])
    );
  end

  function automatic logic [NUM_QUEUES_WIDTH-1:0] rr_search(
    input logic [NUM_QUEUES-1:0]       elig,
    input logic [NUM_QUEUES_WIDTH-1:0] ptr
  );
    logic [NUM_QUEUES_WIDTH-1:0] pick;
    logic [NUM_QUEUES_WIDTH-1:0] idx_w;
    logic                        found;
    int                          idx;
    pick  = ptr;
    found = 1'b0;
    for (int off = 0; off < NUM_QUEUES; off++) begin
      idx = int'(ptr) + off;
      if (idx >= NUM_QUEUES) idx = idx - NUM_QUEUES;
      idx_w = NUM_QUEUES_WIDTH'(idx);
      if (!found && elig[idx_w]) begin
        pick  = idx_w;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign in_rdy      = ~fifo_nearly_full;
  assign eligible    = ~fifo_empty & ~disable_mask;
  assign rr_pick     = rr_search(eligible, rr_ptr);
  assign grant_valid = (state == ARB_XFER);
  assign {head_ctrl, head_data} = fifo_dout[grant_id];

  // A data word (ctrl==0) followed by a nonzero ctrl word closes the packet.
  assign pop = (state == ARB_XFER) && !fifo_empty[grant_id] && out_rdy;
  assign eop = pop && (head_ctrl != '0) && !prev_ctrl;

  always_comb begin
    fifo_rd               = '0;
    fifo_rd[grant_id]     = pop;
    pkt_done_nxt          = '0;
    pkt_done_nxt[grant_id] = eop;
  end

  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant_id;
    prev_ctrl_nxt = prev_ctrl;
    rr_ptr_nxt    = rr_ptr;
    case (state)
      ARB_IDLE: begin
        if (|eligible) begin
          grant_nxt     = rr_pick;
          state_nxt     = ARB_XFER;
          prev_ctrl_nxt = 1'b1;
        end
      end
      ARB_XFER: begin
        if (pop) prev_ctrl_nxt = (head_ctrl != '0);
        if (eop) begin
          state_nxt  = ARB_IDLE;
          rr_ptr_nxt = (grant_id == NUM_QUEUES_WIDTH'(NUM_QUEUES - 1)) ? '0 : grant_id + 1'b1;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ARB_IDLE;
      grant_id  <= '0;
      rr_ptr    <= '0;
      prev_ctrl <= 1'b1;
      out_wr    <= 1'b0;
      out_data  <= '0;
      out_ctrl  <= '0;
      pkt_done  <= '0;
    end else begin
      state     <= state_nxt;
      grant_id  <= grant_nxt;
      rr_ptr    <= rr_ptr_nxt;
      prev_ctrl <= prev_ctrl_nxt;
      out_wr    <= pop;
      pkt_done  <= pkt_done_nxt;
      if (pop) begin
        out_data <= head_data;
        out_ctrl <= head_ctrl;
      end
    end
  end

endmodule

// File: tb/tb_oq_rr_port_arbiter.sv
// Directed bench for oq_rr_port_arbiter: packet-level queue model checked every cycle.
module tb_oq_rr_port_arbiter;

  localparam int DW  = 64;
  localparam int CW  = 8;
  localparam int NQ  = 8;
  localparam int NQW = 3;

  logic             clk;
  logic             reset;
  logic [NQ*DW-1:0] in_data;
  logic [NQ*CW-1:0] in_ctrl;
  logic [NQ-1:0]    in_wr;
  logic [NQ-1:0]    in_rdy;
  logic [DW-1:0]    out_data;
  logic [CW-1:0]    out_ctrl;
  logic             out_wr;
  logic             out_rdy;
  logic [NQ-1:0]    disable_mask;
  logic             grant_valid;
  logic [NQW-1:0]   grant_id;
  logic [NQ-1:0]    pkt_done;

  oq_rr_port_arbiter #(
    .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .NUM_QUEUES(NQ),
    .NUM_QUEUES_WIDTH(NQW), .IN_FIFO_DEPTH_BITS(4)
  ) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr),
    .in_rdy(in_rdy), .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr),
    .out_rdy(out_rdy), .disable_mask(disable_mask), .grant_valid(grant_valid),
    .grant_id(grant_id), .pkt_done(pkt_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [CW-1:0] ctrl;
    bit            last;
  } word_t;

  word_t         mq [NQ][$];
  int            owner_log [$];
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            pkt_seq = 0;
  int            words_seen = 0;
  int            mptr = 0;
  int            owner = 0;
  int            idx;
  int            load_start_cyc = 0;
  int            pkt_first_cyc = 0;
  int            pkt_last_cyc = 0;
  logic [NQW-1:0] first_grant;
  logic [NQ-1:0]  last_done;
  bit            busy = 0;
  bit            found;
  bit            checking = 0;
  bit            prev_last = 0;
  bit            prev_rdy = 1;
  bit            emitted_last;
  word_t         cur;
  logic [DW-1:0] held_data = '0;
  logic [CW-1:0] held_ctrl = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int model_pending();
    int n;
    n = 0;
    for (int i = 0; i < NQ; i++) n += mq[i].size();
    return n;
  endfunction

  // Reference: whole packets leave in round-robin order over inputs holding words and not masked.
  always @(negedge clk) begin
    emitted_last = 1'b0;
    if (checking) begin
      if (out_wr) begin
        if (!busy) begin
          found = 1'b0;
          for (int off = 0; off < NQ; off++) begin
            idx = (mptr + off) % NQ;
            if (!found && mq[idx].size() > 0 && !disable_mask[idx]) begin
              found = 1'b1;
              owner = idx;
            end
          end
          if (found) begin
            busy = 1'b1;
            owner_log.push_back(owner);
            pkt_first_cyc = cyc;
            first_grant = grant_id;
          end else begin
            check("unexpected_word", out_wr, 0);
          end
        end
        if (busy && mq[owner].size() == 0) begin
          check("word_beyond_packet", out_wr, 0);
          busy = 1'b0;
        end else if (busy) begin
          cur = mq[owner].pop_front();
          check("out_data", out_data, cur.data);
          check("out_ctrl", out_ctrl, cur.ctrl);
          check("grant_id", grant_id, owner);
          check("grant_valid", grant_valid, !cur.last);
          check("pkt_done", pkt_done, cur.last ? (64'd1 << owner) : 64'd0);
          words_seen++;
          held_data = cur.data;
          held_ctrl = cur.ctrl;
          if (cur.last) begin
            busy = 1'b0;
            mptr = (owner + 1) % NQ;
            pkt_last_cyc = cyc;
            last_done = pkt_done;
            emitted_last = 1'b1;
          end
        end
      end else begin
        check("pkt_done_idle", pkt_done, 0);
        check("hold_data", out_data, held_data);
        check("hold_ctrl", out_ctrl, held_ctrl);
      end
      if (prev_last) check("gap_after_pkt", out_wr, 0);
      if (!prev_rdy) check("no_pop_rdy_low", out_wr, 0);
      prev_last = emitted_last;
      prev_rdy = out_rdy;
    end
    if (reset) begin
      for (int i = 0; i < NQ; i++) mq[i].delete();
      busy = 1'b0;
      mptr = 0;
      held_data = '0;
      held_ctrl = '0;
      prev_last = 1'b0;
      prev_rdy = 1'b1;
    end
  end

  task automatic load_pkt(input int q, input int nwords, input int nhdr,
                          input logic [CW-1:0] last_ctrl, input bit probe);
    word_t w;
    for (int k = 0; k < nwords; k++) begin
      @(posedge clk); #1;
      if (probe && k == nwords - 1) check("in_rdy_below_nf", in_rdy[q], 1);
      w.data = {8'(q), 8'(pkt_seq), 48'(k)};
      w.ctrl = (k < nhdr) ? (8'hFF - 8'(k)) : ((k == nwords - 1) ? last_ctrl : 8'h00);
      w.last = (k == nwords - 1);
      in_data[q*DW +: DW] = w.data;
      in_ctrl[q*CW +: CW] = w.ctrl;
      in_wr = '0;
      in_wr[q] = 1'b1;
      mq[q].push_back(w);
      if (k == 0) load_start_cyc = cyc;
    end
    @(posedge clk); #1;
    in_wr = '0;
    if (probe) check("in_rdy_at_nf", in_rdy[q], 0);
    pkt_seq++;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || model_pending() != 0) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_drain"}, (n < 300), 1);
    repeat (3) begin @(posedge clk); #1; end
  endtask

  initial begin
    int exp_log [15];
    bit pat [4];
    int n;
    exp_log = '{0, 3, 7, 0, 5, 1, 5, 5, 2, 6, 4, 4, 0, 3, 1};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    reset = 1'b1;
    in_wr = '0;
    in_data = '0;
    in_ctrl = '0;
    out_rdy = 1'b1;
    disable_mask = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_out_wr", out_wr, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ctrl", out_ctrl, 0);
    check("rst_grant_valid", grant_valid, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_pkt_done", pkt_done, 0);
    check("rst_in_rdy", in_rdy, 8'hFF);
    checking = 1'b1;

    // Inputs 0,3,7 loaded together with pointer at 0, then 0 and 5, then 5,5,1.
    disable_mask = 8'hFF;
    load_pkt(0, 4, 1, 8'h40, 0);
    load_pkt(3, 4, 1, 8'h40, 0);
    load_pkt(7, 4, 1, 8'h40, 0);
    disable_mask = '0;
    wait_idle("order_037");
    disable_mask = 8'hFF;
    load_pkt(5, 4, 1, 8'h20, 0);
    load_pkt(0, 4, 1, 8'h20, 0);
    disable_mask = '0;
    wait_idle("order_05");
    disable_mask = 8'hFF;
    load_pkt(5, 4, 1, 8'h02, 0);
    load_pkt(5, 3, 1, 8'h02, 0);
    load_pkt(1, 4, 1, 8'h02, 0);
    disable_mask = '0;
    wait_idle("order_155");

    // Single streamed packet on input 2.
    words_seen = 0;
    load_pkt(2, 5, 1, 8'h08, 0);
    wait_idle("single");
    check("single_latency", pkt_first_cyc - load_start_cyc, 3);
    check("single_span", pkt_last_cyc - pkt_first_cyc, 4);
    check("single_words", words_seen, 5);
    check("single_done", last_done, 8'h04);
    check("single_grant", first_grant, 2);

    // Backpressure pattern 1,0,0,1 across a 6-word packet with two module headers.
    disable_mask = 8'hFF;
    load_pkt(6, 6, 2, 8'h01, 0);
    words_seen = 0;
    disable_mask = '0;
    n = 0;
    while ((busy || model_pending() != 0) && n < 80) begin
      @(posedge clk); #1;
      out_rdy = pat[n % 4];
      n++;
    end
    out_rdy = 1'b1;
    wait_idle("rdy_toggle");
    check("rdy_words", words_seen, 6);

    // Mask input 4 mid-packet; its second packet must wait for the mask to clear.
    disable_mask = 8'hFF;
    load_pkt(4, 4, 1, 8'h10, 0);
    load_pkt(4, 4, 1, 8'h10, 0);
    words_seen = 0;
    disable_mask = '0;
    n = 0;
    while (words_seen < 1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("mask_first_word_seen", (words_seen >= 1), 1);
    disable_mask = 8'h10;
    repeat (25) begin @(posedge clk); #1; end
    check("mask_first_pkt_only", words_seen, 4);
    check("mask_no_grant", grant_valid, 0);
    disable_mask = '0;
    wait_idle("mask_release");
    check("mask_all_words", words_seen, 8);

    // Fill input 0 to the nearly-full threshold.
    disable_mask = 8'hFF;
    load_pkt(0, 15, 1, 8'h04, 1);
    disable_mask = '0;
    wait_idle("nearly_full");

    // Reset after two of five words have left.
    disable_mask = 8'hFF;
    load_pkt(3, 5, 1, 8'h80, 0);
    words_seen = 0;
    disable_mask = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_words", words_seen, 2);
    check("midrst_out_wr", out_wr, 0);
    check("midrst_grant_valid", grant_valid, 0);
    check("midrst_in_rdy", in_rdy, 8'hFF);
    words_seen = 0;
    load_pkt(1, 5, 1, 8'h80, 0);
    wait_idle("post_reset");
    check("post_reset_words", words_seen, 5);

    check("log_len", owner_log.size(), 15);
    for (int i = 0; i < 15; i++) begin
      if (i < owner_log.size()) check("grant_order", owner_log[i], exp_log[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
